// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter/sequencer for a shared single-port SRAM: write ACK at n+2, read ACK at n+3.
// Requests are held by the masters and only sampled in IDLE; requests raised mid-access are served in the next IDLE.
module sram_port_arbiter #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int MAX_BURST         = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         R0_REQ,
  input  logic                         R0_WE,
  input  logic                         R0_LOCK,
  input  logic [MEMORY_ADDR_WIDTH-1:0] R0_A,
  input  logic [MEMORY_DATA_WIDTH-1:0] R0_D,
  output logic                         R0_ACK,
  input  logic                         R1_REQ,
  input  logic                         R1_WE,
  input  logic                         R1_LOCK,
  input  logic [MEMORY_ADDR_WIDTH-1:0] R1_A,
  input  logic [MEMORY_DATA_WIDTH-1:0] R1_D,
  output logic                         R1_ACK,
  output logic [MEMORY_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                   GNT,
  output logic                         BUSY,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  input  logic [MEMORY_DATA_WIDTH-1:0] Q
);

  typedef enum logic [1:0] {IDLE, CMD, RD, DONE} state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic       owner;
  logic       lat_we;
  logic       last_grant;
  logic       last_lock;
  logic [3:0] burst_cnt;

  logic                         win_vld;
  logic                         win;
  logic                         win_we;
  logic [MEMORY_ADDR_WIDTH-1:0] win_a;
  logic [MEMORY_DATA_WIDTH-1:0] win_d;

  // A locked last owner keeps priority until it has used its burst allowance.
  always_comb begin
    win_vld = R0_REQ | R1_REQ;
    win     = 1'b0;
    if (R0_REQ && !R1_REQ)
      win = 1'b0;
    else if (R1_REQ && !R0_REQ)
      win = 1'b1;
    else if (last_lock && (burst_cnt < BURST_LIM))
      win = last_grant;
    else
      win = ~last_grant;
    win_we = win ? R1_WE : R0_WE;
    win_a  = win ? R1_A  : R0_A;
    win_d  = win ? R1_D  : R0_D;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = CMD;
      CMD:     state_nxt = lat_we ? DONE : RD;
      RD:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      last_grant <= 1'b1;
      last_lock  <= 1'b0;
      burst_cnt  <= 4'd0;
      GNT        <= 2'b00;
      R0_ACK     <= 1'b0;
      R1_ACK     <= 1'b0;
      RDATA      <= '0;
      CEN        <= 1'b1;
      WEN        <= 1'b1;
      A          <= '0;
      D          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            owner  <= win;
            lat_we <= win_we;
            GNT    <= win ? 2'b10 : 2'b01;
            CEN    <= 1'b0;
            WEN    <= ~win_we;
            A      <= win_a;
            D      <= win_we ? win_d : '0;
          end
        end
        CMD: begin
          CEN <= 1'b1;
          WEN <= 1'b1;
          A   <= '0;
          D   <= '0;
          if (lat_we) begin
            R0_ACK <= ~owner;
            R1_ACK <= owner;
          end
        end
        RD: begin
          RDATA  <= Q;
          R0_ACK <= ~owner;
          R1_ACK <= owner;
        end
        DONE: begin
          R0_ACK     <= 1'b0;
          R1_ACK     <= 1'b0;
          GNT        <= 2'b00;
          last_grant <= owner;
          last_lock  <= owner ? R1_LOCK : R0_LOCK;
          if (owner != last_grant)
            burst_cnt <= 4'd0;
          else if (burst_cnt != BURST_LIM)
            burst_cnt <= burst_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Two-requester arbiter and sequencer for the shared single-port instruction/data SRAM. Requester 0 is the serial load/fetch I/O controller and requester 1 is the CPU core. It serialises their accesses onto one SRAM port and generates the active-low chip-enable and write-enable strobes. Read data is returned to the winning requester with a handshake. It sits between both masters and the SRAM macro, replacing direct SRAM strobing by either master.

Parameters:
MEMORY_DATA_WIDTH, 8, SRAM word width
MEMORY_ADDR_WIDTH, 9, SRAM address width
MAX_BURST, 4, maximum consecutive grants one LOCKed requester may hold while the other requests (range 1..15)

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  asynchronous active-high reset
R0_REQ  input  1  requester 0 access request; held until R0_ACK
R0_WE  input  1  1=write, 0=read; stable while R0_REQ is high
R0_LOCK  input  1  requester 0 asks to keep priority for its next access
R0_A  input  MEMORY_ADDR_WIDTH  requester 0 address
R0_D  input  MEMORY_DATA_WIDTH  requester 0 write data
R0_ACK  output  1  one-cycle completion pulse to requester 0
R1_REQ, R1_WE, R1_LOCK, R1_A, R1_D, R1_ACK  same as R0_*, for requester 1
RDATA  output  MEMORY_DATA_WIDTH  last read word; valid while the read's ACK is high, then held
GNT  output  2  one-hot current owner; 00 when idle
BUSY  output  1  high in any state other than IDLE
CEN  output  1  SRAM chip enable, active low
WEN  output  1  SRAM write enable, active low
A  output  MEMORY_ADDR_WIDTH  SRAM address; forced to 0 when CEN=1
D  output  MEMORY_DATA_WIDTH  SRAM write data; forced to 0 unless CEN=0 and WEN=0
Q  input  MEMORY_DATA_WIDTH  SRAM read data, valid one cycle after the read command cycle

Behaviour:
- Reset values (asynchronous, any state):
  - state=IDLE, CEN=1, WEN=1, A=0, D=0.
  - R0_ACK=R1_ACK=0, GNT=00, RDATA=0, BUSY=0.
  - last_grant=1, so requester 0 wins the first tie. burst_cnt=0.
- Reset asserted mid-access: the access is dropped with no ACK. The SRAM sees CEN=1 immediately.
- States: IDLE, CMD, RD, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - Otherwise pick a winner, latch winner's WE/A/D and set GNT, then go to CMD.
- Arbitration:
  - Only one REQ high: that requester wins.
  - Both high: the LOCK holder wins if it was the last owner, its LOCK was high at its last DONE, and burst_cnt < MAX_BURST-1.
  - Otherwise round-robin: the requester not equal to last_grant wins.
- CMD (one cycle): CEN=0, A=latched address, WEN=~latched WE, D=latched data for writes. Next state is DONE for a write, RD for a read. All SRAM outputs are registered.
- RD (one cycle): CEN=1, WEN=1. RDATA<=Q at the end of the cycle. Next state is DONE.
- DONE (one cycle):
  - ACK of the owner is high. RDATA is valid for reads. GNT is still the owner.
  - On exit: last_grant<=owner, GNT<=00, state<=IDLE.
  - burst_cnt<=burst_cnt+1 if owner equals the previous owner, else 0.
- Latency from REQ sampled high in IDLE (cycle n):
  - Write: CMD at n+1, ACK at n+2.
  - Read: CMD at n+1, RD at n+2, ACK at n+3.
  - Minimum spacing between grants is 3 cycles (write) or 4 cycles (read).
- Requester rules:
  - Deassert REQ in the cycle after ACK, or keep it high to request again.
  - REQ still high in IDLE after DONE counts as a new request.
  - Changing WE/A/D while REQ is high is illegal. The latched values are used.
- Simultaneous events:
  - REQ rising in any non-IDLE state is held and arbitrated in the next IDLE.
  - A REQ that drops before being granted is ignored.
- Width rules: no arithmetic on data or address. burst_cnt is 4 bits and saturates at MAX_BURST-1.
- RDATA is unchanged by writes.

Test Plan:
1. Reset, then R0 writes A=0x1A5, D=0x3C → CEN=0/WEN=0/A=0x1A5/D=0x3C in cycle n+1; R0_ACK pulses at n+2; GNT=01 during n+1..n+2.
2. R1 reads 0x1A5 with SRAM model returning 0x3C → WEN=1 in CMD; R1_ACK at n+3 with RDATA=0x3C; RDATA holds 0x3C afterwards.
3. R0 and R1 request together from reset, no LOCK, both held → grants alternate 0,1,0,1; each ACK goes to the matching owner; CEN never low for two consecutive cycles.
4. R0_LOCK=1, both requesting continuously, MAX_BURST=4 → R0 granted 4 times in a row, then R1 granted once, then R0 again.
5. Assert RST during the RD state of a read → CEN=1, GNT=00, no ACK, RDATA=0 immediately; the next access after release completes normally.
6. R1_REQ rises during R0's CMD state → R1 is granted in the IDLE that follows R0's DONE, with no lost request and no double ACK.
